uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between N_REQ byte-stream requesters (core, debug monitor, ...).

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART transmitter among N_REQ byte streams
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int LOCK_TIMEOUT = 64,
  parameter int IDX_W        = 2
) (
  input  logic                 clk_g,
  input  logic                 rst_g,
  input  logic [N_REQ-1:0]     istek_gecerli,
  input  logic [8*N_REQ-1:0]   istek_veri,
  input  logic [N_REQ-1:0]     istek_son,
  output logic [N_REQ-1:0]     istek_hazir,
  output logic [31:0]          komut,
  output logic                 komut_gecerli,
  input  logic                 komut_hazir,
  output logic [IDX_W-1:0]     sahip,
  output logic                 mesgul,
  output logic                 zaman_asimi
);
  localparam int NP = 2 ** IDX_W;
  localparam int CW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  typedef enum logic {BOSTA, KILITLI} state_t;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  sahip_q, sahip_d, last_grant_q, last_grant_d, pick, j;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        byte_q, byte_d;
  logic              kv_q, kv_d, zaman_q, zaman_d;
  logic [NP-1:0]     gv, sv, oh;
  logic [8*NP-1:0]   vp;
  logic              any, hz, own_valid, req_xfer, uart_xfer, timed_out;
  // pick the first valid requester after the last grant, wrapping around
  always_comb begin
    gv = NP'(istek_gecerli);
    any = 1'b0;
    pick = sahip_q;
    j = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = IDX_W'((int'(last_grant_q) + k) % N_REQ);
      if (gv[j]) begin
        pick = j;
        any = 1'b1;
      end
    end
  end
  // ready goes only to the owner, and only when the output register can accept
  always_comb begin
    sv = NP'(istek_son);
    vp = (8*NP)'(istek_veri);
    own_valid = gv[sahip_q];
    hz = (state_q == KILITLI) && (!kv_q || komut_hazir);
    oh = '0;
    oh[sahip_q] = hz;
    istek_hazir = N_REQ'(oh);
    req_xfer = hz && own_valid;
    uart_xfer = kv_q && komut_hazir;
    timed_out = (LOCK_TIMEOUT != 0) && !req_xfer && (cnt_q == CW'(LOCK_TIMEOUT - 1));
  end
  // next state: lock bookkeeping, idle counter and the one-entry output register
  always_comb begin
    state_d = state_q;
    sahip_d = sahip_q;
    last_grant_d = last_grant_q;
    cnt_d = cnt_q;
    zaman_d = 1'b0;
    byte_d = req_xfer ? vp[{sahip_q, 3'b000} +: 8] : (uart_xfer ? 8'h00 : byte_q);
    kv_d = req_xfer ? 1'b1 : (uart_xfer ? 1'b0 : kv_q);
    if (state_q == BOSTA) begin
      if (any) begin
        sahip_d = pick;
        state_d = KILITLI;
        cnt_d = '0;
      end
    end else if (req_xfer) begin
      cnt_d = '0;
      if (sv[sahip_q]) begin
        state_d = BOSTA;
        last_grant_d = sahip_q;
      end
    end else if (timed_out) begin
      state_d = BOSTA;
      last_grant_d = sahip_q;
      zaman_d = 1'b1;
    end else if (!own_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  // state registers; reset drops any pending byte
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      state_q <= BOSTA;
      sahip_q <= '0;
      last_grant_q <= IDX_W'(N_REQ - 1);
      cnt_q <= '0;
      byte_q <= '0;
      kv_q <= 1'b0;
      zaman_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sahip_q <= sahip_d;
      last_grant_q <= last_grant_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      kv_q <= kv_d;
      zaman_q <= zaman_d;
    end
  end
  assign komut = {byte_q, 21'b0, 3'b000};
  assign komut_gecerli = kv_q;
  assign sahip = sahip_q;
  assign mesgul = (state_q == KILITLI);
  assign zaman_asimi = zaman_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for the shared UART transmitter arbiter
module tb_uart_tx_arbiter;
  logic        clk_g = 1'b0, rst_g = 1'b1;
  logic [1:0]  istek_gecerli = '0, istek_son = '0, istek_hazir;
  logic [15:0] istek_veri = '0;
  logic [31:0] komut;
  logic        komut_gecerli, komut_hazir = 1'b1;
  logic [1:0]  sahip;
  logic        mesgul, zaman_asimi;
  int          checks = 0, failures = 0;
  logic [8:0]  q0[$], q1[$];
  logic [7:0]  exp_q[$];
  logic        x0 = 1'b0, x1 = 1'b0;

  uart_tx_arbiter #(.N_REQ(2), .LOCK_TIMEOUT(4), .IDX_W(2)) dut (
    .clk_g(clk_g), .rst_g(rst_g), .istek_gecerli(istek_gecerli), .istek_veri(istek_veri),
    .istek_son(istek_son), .istek_hazir(istek_hazir), .komut(komut), .komut_gecerli(komut_gecerli),
    .komut_hazir(komut_hazir), .sahip(sahip), .mesgul(mesgul), .zaman_asimi(zaman_asimi)
  );

  always #5 clk_g = ~clk_g;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor: sample handshakes mid-cycle and compare delivered bytes against the scoreboard
  always @(negedge clk_g) begin
    x0 = !rst_g && istek_gecerli[0] && istek_hazir[0];
    x1 = !rst_g && istek_gecerli[1] && istek_hazir[1];
    if (!rst_g && komut_gecerli && komut_hazir) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_komut actual=%h required=none", komut);
      end else chk("komut", komut, {exp_q.pop_front(), 24'h0});
    end
  end

  // requester models: present the head of each queue, pop it after an accepted transfer
  always @(posedge clk_g) begin
    #1;
    if (x0 && q0.size() > 0) void'(q0.pop_front());
    if (x1 && q1.size() > 0) void'(q1.pop_front());
    istek_gecerli = {q1.size() > 0, q0.size() > 0};
    istek_veri = {q1.size() > 0 ? q1[0][7:0] : 8'h00, q0.size() > 0 ? q0[0][7:0] : 8'h00};
    istek_son = {q1.size() > 0 ? q1[0][8] : 1'b0, q0.size() > 0 ? q0[0][8] : 1'b0};
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk_g);
    #2;
  endtask

  task automatic drain(string nm);
    int t = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0) && t < 300) begin
      cyc(1);
      t++;
    end
    checks++;
    if (t >= 300) begin
      failures++;
      $display("FAIL %s_drain actual=%0d required=0", nm, exp_q.size());
    end
    cyc(2);
  endtask

  task automatic wait_kv(string nm);
    int t = 0;
    while (!komut_gecerli && t < 50) begin
      cyc(1);
      t++;
    end
    chk({nm, "_kv_seen"}, komut_gecerli, 1);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_gecerli"}, komut_gecerli, 0);
    chk({nm, "_komut"}, komut, 0);
    chk({nm, "_hazir"}, istek_hazir, 0);
    chk({nm, "_mesgul"}, mesgul, 0);
    chk({nm, "_zaman"}, zaman_asimi, 0);
    chk({nm, "_sahip"}, sahip, 0);
  endtask

  initial begin
    int t, run;
    cyc(3);
    chk_zero("reset");
    rst_g = 1'b0;
    cyc(1);
    q0.push_back({1'b1, 8'hA1});
    q1.push_back({1'b1, 8'hB1});
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hB1);
    drain("rr_order");
    q1.push_back({1'b0, 8'h41});
    q1.push_back({1'b0, 8'h42});
    q1.push_back({1'b1, 8'h43});
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h30);
    cyc(1);
    q0.push_back({1'b1, 8'h30});
    drain("packet_lock");
    komut_hazir = 1'b0;
    q1.push_back({1'b0, 8'h55});
    q1.push_back({1'b1, 8'h56});
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h56);
    wait_kv("stall");
    for (int i = 0; i < 10; i++) begin
      chk("stall_komut", komut, 32'h5500_0000);
      chk("stall_hazir", istek_hazir, 0);
      cyc(1);
    end
    komut_hazir = 1'b1;
    drain("stall");
    q0.push_back({1'b0, 8'h11});
    exp_q.push_back(8'h11);
    t = 0;
    while (q0.size() > 0 && t < 50) begin
      cyc(1);
      t++;
    end
    chk("timeout_first_byte", q0.size(), 0);
    q1.push_back({1'b1, 8'h22});
    exp_q.push_back(8'h22);
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("timeout_pulse", zaman_asimi, k == 4);
      chk("timeout_mesgul", mesgul, k < 4);
    end
    cyc(1);
    chk("timeout_pulse_end", zaman_asimi, 0);
    chk("timeout_next_owner", sahip, 1);
    chk("timeout_next_mesgul", mesgul, 1);
    drain("timeout");
    komut_hazir = 1'b0;
    q1.push_back({1'b0, 8'h71});
    q1.push_back({1'b1, 8'h72});
    wait_kv("rst_mid");
    chk("rst_mid_mesgul", mesgul, 1);
    rst_g = 1'b1;
    q1.delete();
    cyc(1);
    chk_zero("rst_mid");
    rst_g = 1'b0;
    komut_hazir = 1'b1;
    q0.push_back({1'b1, 8'hA0});
    q1.push_back({1'b1, 8'hB0});
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hB0);
    drain("after_rst");
    for (int i = 0; i < 16; i++) begin
      q0.push_back({i == 15, 8'h60 + 8'(i)});
      exp_q.push_back(8'h60 + 8'(i));
    end
    wait_kv("stream");
    run = 0;
    while (komut_gecerli && run < 40) begin
      run++;
      cyc(1);
    end
    chk("stream_run", run, 16);
    drain("stream");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
